// File: rtl/prio_enc_scan_disp.sv
// Parametrised priority encoder with registered index/flag, hold and change strobe,
// driving a time-multiplexed active-low seven-segment hex display of the index.
module prio_enc_scan_disp #(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IN_W-1:0]           x,
  input  logic                      en,
  input  logic                      hold,
  output logic [$clog2(IN_W)-1:0]   idx,
  output logic                      flag,
  output logic                      chg,
  output logic [6:0]                seg,
  output logic [DIGITS-1:0]         an
);

  localparam int unsigned OUT_W  = $clog2(IN_W);
  localparam int unsigned DISP_W = 4 * DIGITS;
  localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned PTR_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DIGITS - 1);
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_DARK = 7'b1111111;

  if (IN_W < 2) begin : g_chk_in_w
    $error("prio_enc_scan_disp: IN_W must be >= 2");
  end
  if (DIGITS < 1 || DISP_W < OUT_W) begin : g_chk_digits
    $error("prio_enc_scan_disp: 4*DIGITS must cover the index width");
  end
  if (SCAN_DIV < 1) begin : g_chk_scan
    $error("prio_enc_scan_disp: SCAN_DIV must be >= 1");
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [OUT_W-1:0]  enc_idx;
  logic [OUT_W-1:0]  nxt_idx;
  logic              nxt_flag;
  logic [CNT_W-1:0]  cnt;
  logic [PTR_W-1:0]  ptr;
  logic [DISP_W-1:0] disp_val;
  logic [3:0]        nib;
  logic [6:0]        seg_nxt;
  logic [DIGITS-1:0] an_nxt;

  // Ascending scan: the last set bit seen is the highest, so it wins.
  always_comb begin
    enc_idx = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (x[i]) enc_idx = OUT_W'(i);
    end
  end

  assign nxt_flag = en && (|x);
  assign nxt_idx  = en ? enc_idx : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      flag <= 1'b0;
      chg  <= 1'b0;
    end else if (hold) begin
      chg  <= 1'b0;
    end else begin
      idx  <= nxt_idx;
      flag <= nxt_flag;
      chg  <= ({nxt_flag, nxt_idx} != {flag, idx});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ptr <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    disp_val              = '0;
    disp_val[OUT_W-1:0]   = idx;
    nib                   = '0;
    an_nxt                = '1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (ptr == PTR_W'(d)) begin
        nib       = disp_val[4*d +: 4];
        an_nxt[d] = 1'b0;
      end
    end
    seg_nxt = flag ? hex7(nib) : SEG_DASH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_DARK;
      an  <= '1;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_prio_enc_scan_disp.sv
// Directed, table-driven bench for prio_enc_scan_disp: main 16-bit/2-digit instance,
// a 3-digit scan instance and a 9-bit/1-digit instance.
module tb_prio_enc_scan_disp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] x;
  logic [8:0]  x2;
  logic        en, hold;

  logic [3:0]  idx1, idx2, idx3;
  logic        flag1, flag2, flag3, chg1, chg2, chg3;
  logic [6:0]  seg1, seg2, seg3;
  logic [1:0]  an1;
  logic [0:0]  an2;
  logic [2:0]  an3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_enc_scan_disp #(.IN_W(16), .DIGITS(2), .SCAN_DIV(4)) u1 (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .hold(hold),
    .idx(idx1), .flag(flag1), .chg(chg1), .seg(seg1), .an(an1));

  prio_enc_scan_disp #(.IN_W(9), .DIGITS(1), .SCAN_DIV(2)) u2 (
    .clk(clk), .rst_n(rst_n), .x(x2), .en(en), .hold(hold),
    .idx(idx2), .flag(flag2), .chg(chg2), .seg(seg2), .an(an2));

  prio_enc_scan_disp #(.IN_W(16), .DIGITS(3), .SCAN_DIV(4)) u3 (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .hold(hold),
    .idx(idx3), .flag(flag3), .chg(chg3), .seg(seg3), .an(an3));

  typedef struct {
    logic [15:0] x;
    logic        en;
    logic [3:0]  idx;
    logic        flag;
    logic        chg;
    logic [6:0]  s0;
    logic [6:0]  s1;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic got0, got1;
    logic [2:0] exp_an;

    tbl[0] = '{16'h8421, 1'b1, 4'd15, 1'b1, 1'b1, 7'b0001110, 7'b1000000};
    tbl[1] = '{16'h0000, 1'b1, 4'd0,  1'b0, 1'b1, 7'b0111111, 7'b0111111};
    tbl[2] = '{16'hFFFF, 1'b0, 4'd0,  1'b0, 1'b0, 7'b0111111, 7'b0111111};
    tbl[3] = '{16'h0030, 1'b1, 4'd5,  1'b1, 1'b1, 7'b0010010, 7'b1000000};
    tbl[4] = '{16'h0021, 1'b1, 4'd5,  1'b1, 1'b0, 7'b0010010, 7'b1000000};
    tbl[5] = '{16'h0001, 1'b1, 4'd0,  1'b1, 1'b1, 7'b1000000, 7'b1000000};
    tbl[6] = '{16'h0400, 1'b1, 4'd10, 1'b1, 1'b1, 7'b0001000, 7'b1000000};
    tbl[7] = '{16'h1FFF, 1'b1, 4'd12, 1'b1, 1'b1, 7'b1000110, 7'b1000000};
    tbl[8] = '{16'h0005, 1'b1, 4'd2,  1'b1, 1'b1, 7'b0100100, 7'b1000000};

    rst_n = 1'b1; x = '0; x2 = '0; en = 1'b0; hold = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_idx",  32'(idx1), 0);
    chk("rst_flag", 32'(flag1), 0);
    chk("rst_chg",  32'(chg1), 0);
    chk("rst_seg",  32'(seg1), 32'h7F);
    chk("rst_an",   32'(an1), 32'h3);
    chk("rst_an3",  32'(an3), 32'h7);

    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Scan order on the 3-digit instance: each digit lit for 4 cycles, one at a time.
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp_an = ~(3'b001 << (((k - 1) / 4) % 3));
      chk("scan_an3", 32'(an3), 32'(exp_an));
    end
    chk("idle_chg", 32'(chg1), 0);

    for (int v = 0; v < 9; v++) begin
      x = tbl[v].x; en = tbl[v].en;
      tick();
      chk("vec_idx",  32'(idx1),  32'(tbl[v].idx));
      chk("vec_flag", 32'(flag1), 32'(tbl[v].flag));
      chk("vec_chg",  32'(chg1),  32'(tbl[v].chg));
      got0 = 1'b0; got1 = 1'b0;
      for (int c = 0; c < 20 && !(got0 && got1); c++) begin
        tick();
        if (!got0 && an1 == 2'b10) begin
          chk("vec_seg0", 32'(seg1), 32'(tbl[v].s0));
          got0 = 1'b1;
        end else if (!got1 && an1 == 2'b01) begin
          chk("vec_seg1", 32'(seg1), 32'(tbl[v].s1));
          got1 = 1'b1;
        end
      end
      if (!got0) chk("vec_digit0_timeout", 32'(an1), 32'h2);
      if (!got1) chk("vec_digit1_timeout", 32'(an1), 32'h1);
    end

    // Hold freezes idx/flag; release captures the pending input with one chg pulse.
    x = 16'h0030; x2 = 9'h100; en = 1'b1;
    tick();
    chk("pre_hold_idx", 32'(idx1), 5);
    hold = 1'b1; x = 16'h0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_idx", 32'(idx1), 5);
      chk("hold_chg", 32'(chg1), 0);
    end
    hold = 1'b0;
    tick();
    chk("rel_idx", 32'(idx1), 8);
    chk("rel_chg", 32'(chg1), 1);
    tick();
    chk("rel_chg_once", 32'(chg1), 0);
    chk("rel_idx_keep", 32'(idx1), 8);

    hold = 1'b1; en = 1'b0;
    tick();
    chk("hold_en_flag", 32'(flag1), 1);
    chk("hold_en_idx",  32'(idx1), 8);
    hold = 1'b0; en = 1'b1; x = 16'h0002;
    tick();
    chk("unhold_x_idx", 32'(idx1), 1);
    chk("unhold_x_chg", 32'(chg1), 1);

    repeat (3) tick();
    chk("w9_idx",  32'(idx2), 8);
    chk("w9_flag", 32'(flag2), 1);
    chk("w9_seg",  32'(seg2), 32'h00);
    chk("w9_an",   32'(an2), 0);

    // Asynchronous reset between edges, checked before the next edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg",  32'(seg1), 32'h7F);
    chk("mid_rst_an",   32'(an1), 32'h3);
    chk("mid_rst_idx",  32'(idx1), 0);
    chk("mid_rst_flag", 32'(flag1), 0);
    chk("mid_rst_chg",  32'(chg1), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_idx", 32'(idx1), 1);
    chk("post_rst_chg", 32'(chg1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
